tile_bram_loader: RTL and testbench

Write sequencer directly upstream of the L1 tile BRAM. It accepts a load command (start line, line count, side select) and a valid/ready stream of data beats from the dispatcher. It drives the tile BRAM's four parallel write ports (left/right mantissa, left/right exponent), one line per beat, with registered outputs. It signals completion with a one-cycle done pulse.

---
 rtl/tile_bram_pkg.sv | 20 ++
 rtl/tile_bram_loader.sv | 141 ++++++++++++++
 tb/tb_tile_bram_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_bram_pkg.sv
// rtl/tile_bram_pkg.sv - shared constants, side selects and loader state for the tile BRAM write path
package tile_bram_pkg;

  localparam int BRAM_DEPTH = 512;
  localparam int MAN_WIDTH  = 256;
  localparam int EXP_WIDTH  = 8;
  localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH);
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

  localparam logic [1:0] SIDE_LEFT  = 2'b01;
  localparam logic [1:0] SIDE_RIGHT = 2'b10;
  localparam logic [1:0] SIDE_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } loader_state_e;

endpackage

// File: rtl/tile_bram_loader.sv
// rtl/tile_bram_loader.sv - sequences one command's data beats into the tile BRAM left/right write ports
module tile_bram_loader #(
  parameter int MAN_WIDTH  = tile_bram_pkg::MAN_WIDTH,
  parameter int EXP_WIDTH  = tile_bram_pkg::EXP_WIDTH,
  parameter int BRAM_DEPTH = tile_bram_pkg::BRAM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  parameter int LEN_WIDTH  = $clog2(BRAM_DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_start_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic [1:0]            i_cmd_side,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic [MAN_WIDTH-1:0]  i_man_left_data,
  input  logic [MAN_WIDTH-1:0]  i_man_right_data,
  input  logic [EXP_WIDTH-1:0]  i_exp_left_data,
  input  logic [EXP_WIDTH-1:0]  i_exp_right_data,
  output logic [ADDR_WIDTH-1:0] o_man_left_wr_addr,
  output logic                  o_man_left_wr_en,
  output logic [MAN_WIDTH-1:0]  o_man_left_wr_data,
  output logic [ADDR_WIDTH-1:0] o_man_right_wr_addr,
  output logic                  o_man_right_wr_en,
  output logic [MAN_WIDTH-1:0]  o_man_right_wr_data,
  output logic [ADDR_WIDTH-1:0] o_exp_left_wr_addr,
  output logic                  o_exp_left_wr_en,
  output logic [EXP_WIDTH-1:0]  o_exp_left_wr_data,
  output logic [ADDR_WIDTH-1:0] o_exp_right_wr_addr,
  output logic                  o_exp_right_wr_en,
  output logic [EXP_WIDTH-1:0]  o_exp_right_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cmd_err
);

  import tile_bram_pkg::*;

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_inc;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [1:0]            side_q;
  logic                  cmd_ready_q;
  logic                  cmd_err_q;
  logic                  cmd_fire, cmd_bad, beat_fire, last_beat;

  logic [ADDR_WIDTH-1:0] left_addr_q, right_addr_q;
  logic                  left_en_q, right_en_q;
  logic [MAN_WIDTH-1:0]  man_left_q, man_right_q;
  logic [EXP_WIDTH-1:0]  exp_left_q, exp_right_q;

  assign cmd_fire  = (state_q == ST_IDLE) && cmd_ready_q && i_cmd_valid;
  assign cmd_bad   = (i_cmd_len == '0) || (i_cmd_len > LEN_WIDTH'(BRAM_DEPTH)) ||
                     (i_cmd_side == 2'b00);
  assign beat_fire = (state_q == ST_WRITE) && i_data_valid;
  assign last_beat = beat_fire && (remaining_q == LEN_WIDTH'(1));
  assign ptr_inc   = (ptr_q == ADDR_WIDTH'(BRAM_DEPTH - 1)) ? '0 : ptr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_fire && !cmd_bad) state_d = ST_WRITE;
      ST_WRITE: if (last_beat) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // cmd_ready is registered so it stays low while reset is held and rises on the first clock after release
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      ptr_q       <= '0;
      remaining_q <= '0;
      side_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      cmd_err_q   <= cmd_fire && cmd_bad;
      if (cmd_fire) begin
        ptr_q       <= i_cmd_start_addr;
        remaining_q <= i_cmd_len;
        side_q      <= i_cmd_side;
      end else if (beat_fire) begin
        ptr_q       <= ptr_inc;
        remaining_q <= remaining_q - LEN_WIDTH'(1);
      end
    end
  end

  // Address and data hold between beats; only the enables drop back to zero
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      left_en_q    <= 1'b0;
      right_en_q   <= 1'b0;
      left_addr_q  <= '0;
      right_addr_q <= '0;
      man_left_q   <= '0;
      man_right_q  <= '0;
      exp_left_q   <= '0;
      exp_right_q  <= '0;
    end else begin
      left_en_q  <= beat_fire && ((side_q & SIDE_LEFT) != 2'b00);
      right_en_q <= beat_fire && ((side_q & SIDE_RIGHT) != 2'b00);
      if (beat_fire && ((side_q & SIDE_LEFT) != 2'b00)) begin
        left_addr_q <= ptr_q;
        man_left_q  <= i_man_left_data;
        exp_left_q  <= i_exp_left_data;
      end
      if (beat_fire && ((side_q & SIDE_RIGHT) != 2'b00)) begin
        right_addr_q <= ptr_q;
        man_right_q  <= i_man_right_data;
        exp_right_q  <= i_exp_right_data;
      end
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_data_ready = (state_q == ST_WRITE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_cmd_err    = cmd_err_q;

  assign o_man_left_wr_addr  = left_addr_q;
  assign o_man_left_wr_en    = left_en_q;
  assign o_man_left_wr_data  = man_left_q;
  assign o_exp_left_wr_addr  = left_addr_q;
  assign o_exp_left_wr_en    = left_en_q;
  assign o_exp_left_wr_data  = exp_left_q;
  assign o_man_right_wr_addr = right_addr_q;
  assign o_man_right_wr_en   = right_en_q;
  assign o_man_right_wr_data = man_right_q;
  assign o_exp_right_wr_addr = right_addr_q;
  assign o_exp_right_wr_en   = right_en_q;
  assign o_exp_right_wr_data = exp_right_q;

endmodule

// File: tb/tb_tile_bram_loader.sv
// tb/tb_tile_bram_loader.sv - randomized bench for tile_bram_loader against a line-level loader model
module tb_tile_bram_loader;
  import tile_bram_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int LW    = LEN_WIDTH;
  localparam int MW    = MAN_WIDTH;
  localparam int EW    = EXP_WIDTH;
  localparam int DEPTH = BRAM_DEPTH;

  logic          i_clk, i_reset_n;
  logic          i_cmd_valid, o_cmd_ready;
  logic [AW-1:0] i_cmd_start_addr;
  logic [LW-1:0] i_cmd_len;
  logic [1:0]    i_cmd_side;
  logic          i_data_valid, o_data_ready;
  logic [MW-1:0] i_man_left_data, i_man_right_data;
  logic [EW-1:0] i_exp_left_data, i_exp_right_data;
  logic [AW-1:0] o_man_left_wr_addr, o_man_right_wr_addr, o_exp_left_wr_addr, o_exp_right_wr_addr;
  logic          o_man_left_wr_en, o_man_right_wr_en, o_exp_left_wr_en, o_exp_right_wr_en;
  logic [MW-1:0] o_man_left_wr_data, o_man_right_wr_data;
  logic [EW-1:0] o_exp_left_wr_data, o_exp_right_wr_data;
  logic          o_busy, o_done, o_cmd_err;

  tile_bram_loader dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_start_addr(i_cmd_start_addr), .i_cmd_len(i_cmd_len), .i_cmd_side(i_cmd_side),
    .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
    .i_man_left_data(i_man_left_data), .i_man_right_data(i_man_right_data),
    .i_exp_left_data(i_exp_left_data), .i_exp_right_data(i_exp_right_data),
    .o_man_left_wr_addr(o_man_left_wr_addr), .o_man_left_wr_en(o_man_left_wr_en),
    .o_man_left_wr_data(o_man_left_wr_data),
    .o_man_right_wr_addr(o_man_right_wr_addr), .o_man_right_wr_en(o_man_right_wr_en),
    .o_man_right_wr_data(o_man_right_wr_data),
    .o_exp_left_wr_addr(o_exp_left_wr_addr), .o_exp_left_wr_en(o_exp_left_wr_en),
    .o_exp_left_wr_data(o_exp_left_wr_data),
    .o_exp_right_wr_addr(o_exp_right_wr_addr), .o_exp_right_wr_en(o_exp_right_wr_en),
    .o_exp_right_wr_data(o_exp_right_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_cmd_err(o_cmd_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line-level model: a command opens a window of len lines; every accepted beat lands on the next line.
  logic          e_cmd_ready, e_data_ready, e_busy, e_done, e_err, e_en_l, e_en_r;
  logic [AW-1:0] e_addr_l, e_addr_r;
  logic [MW-1:0] e_man_l, e_man_r;
  logic [EW-1:0] e_exp_l, e_exp_r;
  int            m_ptr, m_rem;
  logic [1:0]    m_side;
  logic [MW-1:0] g_man_l [DEPTH];
  logic [MW-1:0] g_man_r [DEPTH];
  logic [EW-1:0] g_exp_l [DEPTH];
  logic [EW-1:0] g_exp_r [DEPTH];
  int            n_ptr, n_rem;
  logic          acc_cmd, acc_beat, cmd_bad, n_done;

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      e_cmd_ready <= 0; e_data_ready <= 0; e_busy <= 0; e_done <= 0; e_err <= 0;
      e_en_l <= 0; e_en_r <= 0; e_addr_l <= '0; e_addr_r <= '0;
      e_man_l <= '0; e_man_r <= '0; e_exp_l <= '0; e_exp_r <= '0;
      m_ptr <= 0; m_rem <= 0; m_side <= 2'b00;
    end else begin
      acc_cmd  = e_cmd_ready && i_cmd_valid;
      acc_beat = e_data_ready && i_data_valid;
      n_ptr  = m_ptr;
      n_rem  = m_rem;
      n_done = 1'b0;
      e_en_l <= 1'b0;
      e_en_r <= 1'b0;
      if (acc_beat) begin
        if (m_side[0]) begin
          e_en_l <= 1'b1; e_addr_l <= AW'(m_ptr);
          e_man_l <= i_man_left_data; e_exp_l <= i_exp_left_data;
          g_man_l[m_ptr] <= i_man_left_data; g_exp_l[m_ptr] <= i_exp_left_data;
        end
        if (m_side[1]) begin
          e_en_r <= 1'b1; e_addr_r <= AW'(m_ptr);
          e_man_r <= i_man_right_data; e_exp_r <= i_exp_right_data;
          g_man_r[m_ptr] <= i_man_right_data; g_exp_r[m_ptr] <= i_exp_right_data;
        end
        n_ptr  = (m_ptr + 1) % DEPTH;
        n_rem  = m_rem - 1;
        n_done = (n_rem == 0);
      end
      cmd_bad = (int'(i_cmd_len) == 0) || (int'(i_cmd_len) > DEPTH) || (i_cmd_side == 2'b00);
      if (acc_cmd && !cmd_bad) begin
        n_ptr = int'(i_cmd_start_addr);
        n_rem = int'(i_cmd_len);
        m_side <= i_cmd_side;
      end
      m_ptr        <= n_ptr;
      m_rem        <= n_rem;
      e_done       <= n_done;
      e_err        <= acc_cmd && cmd_bad;
      e_data_ready <= (n_rem != 0);
      e_busy       <= (n_rem != 0) || n_done;
      e_cmd_ready  <= !((n_rem != 0) || n_done);
    end
  end

  // Shadow of what the DUT actually wrote, plus traces used by the literal checks
  logic [MW-1:0] s_man_l [DEPTH];
  logic [MW-1:0] s_man_r [DEPTH];
  logic [EW-1:0] s_exp_l [DEPTH];
  logic [EW-1:0] s_exp_r [DEPTH];
  int l_trace[$];
  int r_trace[$];
  int done_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int done_addr_l = -1, done_addr_r = -1;

  always @(negedge i_clk) begin
    chk("cmd_ready", o_cmd_ready, e_cmd_ready);
    chk("data_ready", o_data_ready, e_data_ready);
    chk("busy", o_busy, e_busy);
    chk("done", o_done, e_done);
    chk("cmd_err", o_cmd_err, e_err);
    chk("man_l_en", o_man_left_wr_en, e_en_l);
    chk("exp_l_en", o_exp_left_wr_en, e_en_l);
    chk("man_r_en", o_man_right_wr_en, e_en_r);
    chk("exp_r_en", o_exp_right_wr_en, e_en_r);
    chk("man_l_addr", o_man_left_wr_addr, e_addr_l);
    chk("exp_l_addr", o_exp_left_wr_addr, e_addr_l);
    chk("man_r_addr", o_man_right_wr_addr, e_addr_r);
    chk("exp_r_addr", o_exp_right_wr_addr, e_addr_r);
    chk("man_l_data", o_man_left_wr_data, e_man_l);
    chk("man_r_data", o_man_right_wr_data, e_man_r);
    chk("exp_l_data", o_exp_left_wr_data, e_exp_l);
    chk("exp_r_data", o_exp_right_wr_data, e_exp_r);
    if (o_man_left_wr_en) begin
      s_man_l[o_man_left_wr_addr] <= o_man_left_wr_data;
      s_exp_l[o_exp_left_wr_addr] <= o_exp_left_wr_data;
      l_trace.push_back(int'(o_man_left_wr_addr));
    end
    if (o_man_right_wr_en) begin
      s_man_r[o_man_right_wr_addr] <= o_man_right_wr_data;
      s_exp_r[o_exp_right_wr_addr] <= o_exp_right_wr_data;
      r_trace.push_back(int'(o_man_right_wr_addr));
    end
    if (o_done) begin
      done_cnt    <= done_cnt + 1;
      done_addr_l <= int'(o_man_left_wr_addr);
      done_addr_r <= int'(o_man_right_wr_addr);
    end
    if (o_cmd_err) err_cnt <= err_cnt + 1;
    if (o_busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic rand_beat_data();
    logic [MW-1:0] a, b;
    for (int w = 0; w < MW / 32; w++) begin
      a[w*32 +: 32] = $urandom();
      b[w*32 +: 32] = $urandom();
    end
    i_man_left_data  = a;
    i_man_right_data = b;
    i_exp_left_data  = EW'($urandom());
    i_exp_right_data = EW'($urandom());
  endtask

  task automatic send_cmd(input int start, input int len, input logic [1:0] side);
    int t = 0;
    while (o_cmd_ready !== 1'b1 && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    chk("cmd_ready_wait", o_cmd_ready, 1'b1);
    i_cmd_valid      = 1'b1;
    i_cmd_start_addr = AW'(start);
    i_cmd_len        = LW'(len);
    i_cmd_side       = side;
    @(negedge i_clk);
    i_cmd_valid      = 1'b0;
    i_cmd_start_addr = AW'($urandom());
    i_cmd_len        = LW'($urandom());
    i_cmd_side       = 2'($urandom());
  endtask

  // mode 0: continuous, 1: alternating starting with valid, 2: random valid plus stray commands
  task automatic send_beats(input int n, input int mode);
    int acc = 0;
    int t   = 0;
    logic v;
    while (acc < n && t < 3000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 2) == 0) : ($urandom_range(0, 3) != 0);
      i_data_valid = v;
      rand_beat_data();
      if (mode == 2) begin
        i_cmd_valid      = ($urandom_range(0, 3) == 0);
        i_cmd_start_addr = AW'($urandom());
        i_cmd_len        = LW'($urandom_range(1, 20));
        i_cmd_side       = 2'($urandom_range(1, 3));
      end
      if (v && o_data_ready) acc++;
      @(negedge i_clk);
      t++;
    end
    i_data_valid = 1'b0;
    i_cmd_valid  = 1'b0;
    chk("beats_accepted", acc, n);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
    #1;
  endtask

  task automatic check_trace(input string name, input int q[$], input int exp[$]);
    chk({name, "_len"}, q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q.size(); i++)
      chk(name, q[i], exp[i]);
  endtask

  int base_done, base_err, base_busy;

  initial begin
    i_reset_n = 1'b0; i_cmd_valid = 1'b0; i_data_valid = 1'b0;
    i_cmd_start_addr = '0; i_cmd_len = '0; i_cmd_side = 2'b00;
    i_man_left_data = '0; i_man_right_data = '0; i_exp_left_data = '0; i_exp_right_data = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_cmd_ready", o_cmd_ready, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_l_addr", o_man_left_wr_addr, '0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    chk("post_reset_cmd_ready", o_cmd_ready, 1'b1);

    // Both sides, four back-to-back beats
    l_trace.delete(); r_trace.delete(); base_done = done_cnt;
    send_cmd(0, 4, SIDE_BOTH);
    send_beats(4, 0);
    idle_cycles(3);
    check_trace("t1_left", l_trace, '{0, 1, 2, 3});
    check_trace("t1_right", r_trace, '{0, 1, 2, 3});
    chk("t1_done_cnt", done_cnt - base_done, 1);
    chk("t1_done_addr", done_addr_l, 3);

    // Left only across the wrap point
    l_trace.delete(); r_trace.delete();
    send_cmd(510, 4, SIDE_LEFT);
    send_beats(4, 0);
    idle_cycles(3);
    check_trace("t2_left", l_trace, '{510, 511, 0, 1});
    chk("t2_right_writes", r_trace.size(), 0);

    // Right only with gapped beats
    l_trace.delete(); r_trace.delete();
    send_cmd(0, 3, SIDE_RIGHT);
    send_beats(3, 1);
    idle_cycles(3);
    check_trace("t3_right", r_trace, '{0, 1, 2});
    chk("t3_left_writes", l_trace.size(), 0);
    chk("t3_done_addr", done_addr_r, 2);

    // Rejected commands, then a good one
    l_trace.delete(); r_trace.delete();
    base_err = err_cnt; base_busy = busy_cnt; base_done = done_cnt;
    send_cmd(5, 0, SIDE_BOTH);
    send_cmd(5, 513, SIDE_BOTH);
    send_cmd(5, 2, 2'b00);
    idle_cycles(3);
    chk("t4_err_cnt", err_cnt - base_err, 3);
    chk("t4_busy_cycles", busy_cnt - base_busy, 0);
    chk("t4_writes", l_trace.size() + r_trace.size(), 0);
    send_cmd(7, 1, SIDE_LEFT);
    send_beats(1, 0);
    idle_cycles(3);
    check_trace("t4_left", l_trace, '{7});
    chk("t4_done_cnt", done_cnt - base_done, 1);

    // Randomized commands, with stray beats offered while idle
    for (int k = 0; k < 12; k++) begin
      i_data_valid = 1'b1;
      rand_beat_data();
      @(negedge i_clk);
      i_data_valid = 1'b0;
      if ($urandom_range(0, 4) == 0)
        send_cmd($urandom_range(0, DEPTH - 1), ($urandom_range(0, 1) == 0) ? 0 : 600, 2'($urandom_range(0, 3)));
      send_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, 24), 2'($urandom_range(1, 3)));
      send_beats(int'(i_cmd_len) == 0 ? 0 : 0, 0);
      send_beats(int'(m_rem), 2);
      idle_cycles(2);
    end

    // Reset in the middle of a command
    base_done = done_cnt;
    send_cmd(100, 8, SIDE_BOTH);
    send_beats(2, 0);
    i_data_valid = 1'b1;
    #2 i_reset_n = 1'b0;
    #1;
    chk("rst_l_en", o_man_left_wr_en, 1'b0);
    chk("rst_r_en", o_man_right_wr_en, 1'b0);
    chk("rst_l_addr", o_man_left_wr_addr, '0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_data_ready", o_data_ready, 1'b0);
    chk("rst_cmd_ready", o_cmd_ready, 1'b0);
    i_data_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    #1;
    chk("rst_release_cmd_ready", o_cmd_ready, 1'b1);
    chk("rst_no_done", done_cnt - base_done, 0);

    // Full-depth load after reset
    l_trace.delete(); r_trace.delete(); base_done = done_cnt;
    send_cmd(0, DEPTH, SIDE_BOTH);
    send_beats(DEPTH, 2);
    idle_cycles(3);
    chk("t5_left_writes", l_trace.size(), DEPTH);
    chk("t5_right_writes", r_trace.size(), DEPTH);
    chk("t5_done_cnt", done_cnt - base_done, 1);
    chk("t5_done_addr", done_addr_l, DEPTH - 1);
    if (l_trace.size() == DEPTH) begin
      chk("t5_first_addr", l_trace[0], 0);
      chk("t5_last_addr", l_trace[DEPTH-1], DEPTH - 1);
    end

    for (int a = 0; a < DEPTH; a++) begin
      chk("rb_man_l", s_man_l[a], g_man_l[a]);
      chk("rb_man_r", s_man_r[a], g_man_r[a]);
      chk("rb_exp_l", s_exp_l[a], g_exp_l[a]);
      chk("rb_exp_r", s_exp_r[a], g_exp_r[a]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
